// File: rtl/spi_reg_writer.sv
// SPI mode-0 initiator: serialises one {1'b1, addr, wdata} write frame per request, MSB first.
// Define SPI_QUEUE_EN to add a one-entry request holding register.
module spi_reg_writer #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic       ready,
    output logic       done,
    output logic       nCS,
    output logic       SCLK,
    output logic       copi
);

    localparam logic [7:0] DivReload = 8'(CLK_DIV - 1);

    if (CLK_DIV < 2 || CLK_DIV > 255) begin : gen_bad_div
        $error("spi_reg_writer: CLK_DIV must be within 2..255");
    end

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StHold,
        StGap
    } state_e;

    state_e      state_q;
    logic [7:0]  div_q;
    logic [3:0]  bit_q;
    logic [15:0] shift_q;

    logic        accept;
    logic        phase_end;
    logic        launch;
    logic [15:0] req_frame;
    logic [15:0] launch_frame;

    assign accept    = start && ready;
    assign phase_end = (div_q == 8'd0);
    assign req_frame = {1'b1, addr, wdata};

`ifdef SPI_QUEUE_EN
    logic        slot_valid_q;
    logic [15:0] slot_q;
    logic        store;

    // Any request taken while not idle parks in the slot, including one on the final GAP edge.
    assign store        = accept && (state_q != StIdle);
    assign launch       = ((state_q == StIdle) && (slot_valid_q || accept)) ||
                          ((state_q == StGap) && phase_end && slot_valid_q);
    assign launch_frame = slot_valid_q ? slot_q : req_frame;
`else
    assign launch       = (state_q == StIdle) && accept;
    assign launch_frame = req_frame;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            div_q   <= 8'd0;
            bit_q   <= 4'd0;
            shift_q <= 16'd0;
            nCS     <= 1'b1;
            SCLK    <= 1'b0;
            copi    <= 1'b0;
            ready   <= 1'b1;
            done    <= 1'b0;
`ifdef SPI_QUEUE_EN
            slot_valid_q <= 1'b0;
            slot_q       <= 16'd0;
`endif
        end else begin
            done <= 1'b0;

            if (launch) begin
                state_q <= StShift;
                shift_q <= launch_frame;
                bit_q   <= 4'd15;
                div_q   <= DivReload;
                nCS     <= 1'b0;
                SCLK    <= 1'b0;
                copi    <= launch_frame[15];
            end else begin
                unique case (state_q)
                    StIdle: begin
                        div_q <= DivReload;
                    end
                    StShift: begin
                        if (!phase_end) begin
                            div_q <= div_q - 8'd1;
                        end else begin
                            div_q <= DivReload;
                            if (!SCLK) begin
                                SCLK <= 1'b1;
                            end else begin
                                // Falling edge: advance to the next bit or leave after bit 0.
                                SCLK <= 1'b0;
                                if (bit_q == 4'd0) begin
                                    state_q <= StHold;
                                    copi    <= 1'b0;
                                end else begin
                                    bit_q   <= bit_q - 4'd1;
                                    shift_q <= {shift_q[14:0], 1'b0};
                                    copi    <= shift_q[14];
                                end
                            end
                        end
                    end
                    StHold: begin
                        if (!phase_end) begin
                            div_q <= div_q - 8'd1;
                        end else begin
                            div_q   <= DivReload;
                            state_q <= StGap;
                            nCS     <= 1'b1;
                            done    <= 1'b1;
                        end
                    end
                    StGap: begin
                        if (!phase_end) begin
                            div_q <= div_q - 8'd1;
                        end else begin
                            div_q   <= DivReload;
                            state_q <= StIdle;
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end

`ifdef SPI_QUEUE_EN
            // ready mirrors an empty slot; the slot only fills when ready was high.
            if (store) begin
                slot_valid_q <= 1'b1;
                slot_q       <= req_frame;
                ready        <= 1'b0;
            end else if (launch && slot_valid_q) begin
                slot_valid_q <= 1'b0;
                ready        <= 1'b1;
            end
`else
            if (launch) begin
                ready <= 1'b0;
            end else if ((state_q == StGap) && phase_end) begin
                ready <= 1'b1;
            end
`endif
        end
    end

    // Bus-level invariants.
    a_sclk_idle_low : assert property (@(posedge clk) disable iff (rst) nCS |-> !SCLK);
    a_done_with_ncs : assert property (@(posedge clk) disable iff (rst) done |-> nCS);
    a_copi_stable   : assert property (@(posedge clk) disable iff (rst)
                                       (SCLK && $past(SCLK)) |-> $stable(copi));

endmodule

// File: tb/tb_spi_reg_writer.sv
// Scoreboard bench for spi_reg_writer: a bus monitor/peripheral model decodes frames on
// SCLK rises and compares them against frames queued at each accept edge.
module tb_spi_reg_writer;

    localparam int unsigned D = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic       ready;
    logic       done;
    logic       nCS;
    logic       SCLK;
    logic       copi;

    spi_reg_writer #(
        .CLK_DIV(D)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .addr (addr),
        .wdata(wdata),
        .ready(ready),
        .done (done),
        .nCS  (nCS),
        .SCLK (SCLK),
        .copi (copi)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int e = 0;
    logic rst_edge = 1'b1;

    always @(posedge clk) begin
        e        <= e + 1;
        rst_edge <= rst;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Peripheral model and scoreboard
    logic [15:0] exp_q[$];
    logic [7:0]  regs[128];
    logic [15:0] rx = 16'd0;
    int rises = 0;
    int frames_ok = 0;
    int ncs_falls = 0;
    int done_cnt = 0;
    int first_rise_e = 0;
    int last_rise_e = 0;
    int last_fall_e = 0;
    int last_done_e = 0;
    logic sclk_prev = 1'b0;
    logic ncs_prev = 1'b1;
    logic copi_prev = 1'b0;

    always @(negedge clk) begin
        if (!nCS) begin
            if (SCLK && !sclk_prev) begin
                rx = {rx[14:0], copi};
                rises++;
                if (rises == 1) first_rise_e = e;
                last_rise_e = e;
            end
            if (SCLK && sclk_prev) check("copi_stable", copi, copi_prev);
        end
        if (!nCS && ncs_prev) begin
            ncs_falls++;
            last_fall_e = e;
            rises = 0;
        end
        if (nCS && !ncs_prev) begin
            // Partial frames (reset mid-frame) are discarded like the real peripheral does.
            if (rises == 16) begin
                check("sb_nonempty", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) check("frame", rx, exp_q.pop_front());
                regs[rx[14:8]] = rx[7:0];
                frames_ok++;
            end
            rises = 0;
        end
        if (done) begin
            done_cnt++;
            last_done_e = e;
        end
        if (!rst_edge && (done || (nCS && !ncs_prev))) check("done_at_ncs_rise", done, nCS && !ncs_prev);
        sclk_prev = SCLK;
        ncs_prev  = nCS;
        copi_prev = copi;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [6:0] a, input logic [7:0] d, output int t0);
        step();
        check("ready_before_send", ready, 1);
        start = 1'b1;
        addr  = a;
        wdata = d;
        exp_q.push_back({1'b1, a, d});
        t0 = e + 1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (!(ready && nCS && exp_q.size() == 0) && n < budget) begin
            step();
            n++;
        end
        check("idle_timeout", 32'(n < budget), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0;
        int n;
        int c;
        int f;
        int d1;
        foreach (regs[i]) regs[i] = 8'h00;
        rst   = 1'b1;
        start = 1'b0;
        addr  = 7'h00;
        wdata = 8'h00;
        repeat (3) step();
        rst = 1'b0;

        // Idle after reset: {nCS, SCLK, copi, ready, done}
        for (int i = 0; i < 10; i++) begin
            step();
            check("idle_outputs", {nCS, SCLK, copi, ready, done}, 5'b10010);
        end

        // Basic write and frame timing (edge offsets from the accept edge)
        send(7'h04, 8'hA5, t0);
        wait_idle(1000);
        check("first_rise", first_rise_e - t0, D);
        check("last_rise", last_rise_e - t0, 31 * D);
        check("done_time", last_done_e - t0, 33 * D);
        check("duty_reg", regs[4], 8'hA5);
        check("frames_basic", frames_ok, 1);
`ifndef SPI_QUEUE_EN
        check("ready_time", e - t0, 34 * D);

        // start while busy is ignored
        n = frames_ok;
        c = ncs_falls;
        send(7'h10, 8'h3C, t0);
        while (e < t0 + 9) step();
        check("busy_ready_low", ready, 0);
        start = 1'b1;
        addr  = 7'h00;
        wdata = 8'hFF;
        step();
        start = 1'b0;
        wait_idle(1000);
        check("busy_frames", frames_ok - n, 1);
        check("busy_ncs_falls", ncs_falls - c, 1);
        check("busy_reg0", regs[0], 8'h00);
        check("busy_reg10", regs[16], 8'h3C);
`endif

        // Reset in the middle of a frame
        c = done_cnt;
        send(7'h05, 8'h77, t0);
        while (e < t0 + 49) step();
        rst = 1'b1;
        step();
        check("rst_outputs", {nCS, SCLK, copi, ready, done}, 5'b10010);
        rst = 1'b0;
        exp_q.delete();
        repeat (40 * D) step();
        check("rst_no_done", done_cnt - c, 0);
        check("rst_reg_unchanged", regs[5], 8'h00);

        // start held high while addr/wdata change every cycle
        n = 0;
        c = frames_ok;
        start = 1'b1;
        for (int k = 0; k < 2000 && n < 3; k++) begin
            addr  = 7'($urandom);
            wdata = 8'($urandom);
            if (ready) begin
                exp_q.push_back({1'b1, addr, wdata});
                n++;
            end
            step();
        end
        start = 1'b0;
        wait_idle(2000);
        check("held_accepts", n, 3);
        check("held_frames", frames_ok - c, 3);

`ifdef SPI_QUEUE_EN
        // Two requests back to back through the holding register
        c = ncs_falls;
        f = done_cnt;
        d1 = 0;
        send(7'h01, 8'h11, t0);
        while (e < t0 + 4) step();
        check("q_ready_busy", ready, 1);
        start = 1'b1;
        addr  = 7'h02;
        wdata = 8'h22;
        exp_q.push_back({1'b1, 7'h02, 8'h22});
        step();
        start = 1'b0;
        n = 0;
        while (ncs_falls - c < 2 && n < 1000) begin
            check("q_ready_held_low", ready, 0);
            if (done_cnt - f == 1 && d1 == 0) d1 = last_done_e;
            step();
            n++;
        end
        check("q_fall_timeout", 32'(n < 1000), 1);
        check("q_fall2", last_fall_e - t0, 34 * D);
        check("q_done1", d1 - t0, 33 * D);
        wait_idle(1000);
        check("q_done2", last_done_e - last_fall_e, 33 * D);
        check("q_done_count", done_cnt - f, 2);
        check("q_reg2", regs[2], 8'h22);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
